// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx serializer among NUM_REQ byte producers.
// Optional frame watchdog with a sticky timeout_err flag: define UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched #(
    parameter int NUM_REQ = 4
`ifdef UART_TX_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1200
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_send,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
`ifdef UART_TX_SCHED_TIMEOUT_EN
    ,
    output logic                       timeout_err
`endif
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             state_reg;
    logic [7:0]         req_bytes [NUM_REQ];
    logic [NUM_REQ-1:0] above_mask;
    logic [NUM_REQ-1:0] upper_valid;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDW-1:0]     win_idx;
    logic               any_valid;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt_reg;
`endif

    // Lowest-numbered set bit; the caller guarantees at least one bit is set.
    function automatic logic [IDW-1:0] lowest(input logic [NUM_REQ-1:0] v);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDW'(i);
            end
        end
        return idx;
    endfunction

    // Requesters above the last grant get first pick, then the search wraps to 0.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_bytes[gi]  = req_data[8*gi +: 8];
            assign above_mask[gi] = (IDW'(gi) > grant_id);
            assign win_onehot[gi] = any_valid && (win_idx == IDW'(gi));
        end
    endgenerate

    assign any_valid   = |req_valid;
    assign upper_valid = req_valid & above_mask;
    assign win_idx     = (|upper_valid) ? lowest(upper_valid) : lowest(req_valid);

    // Gated by rst_n so no producer sees an accept while the block is held in reset.
    assign req_ready = (rst_n && (state_reg == ST_IDLE)) ? win_onehot : '0;
    assign busy      = (state_reg != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            tx_data      <= 8'h00;
            tx_send      <= 1'b0;
            grant_id     <= IDW'(NUM_REQ - 1);
`ifdef UART_TX_SCHED_TIMEOUT_EN
            wait_cnt_reg <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            tx_send <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (any_valid) begin
                        tx_data   <= req_bytes[win_idx];
                        grant_id  <= win_idx;
                        tx_send   <= 1'b1;
                        state_reg <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    state_reg <= ST_WAIT;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                end
                ST_WAIT: begin
                    // tx_data stays put here: the serializer re-samples it in its start bit.
                    if (tx_done) begin
                        state_reg <= ST_IDLE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    end else if (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                        state_reg   <= ST_IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
`endif
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a behavioural uart_tx serializer model.
// Exercises the watchdog as well when UART_TX_SCHED_TIMEOUT_EN is defined.
module tb_uart_tx_sched;

    localparam int NR = 4;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int TPB = 4;
    localparam int TMO = 50;
`else
    localparam int TPB = 104;
`endif
    localparam int BUDGET = 12 * TPB + 20;

    logic          clk;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic [7:0]    tx_data;
    logic          tx_send;
    logic          tx_done;
    logic          busy;
    logic [1:0]    grant_id;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic          timeout_err;
`endif

    uart_tx_sched #(
        .NUM_REQ(NR)
`ifdef UART_TX_SCHED_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .tx_data(tx_data),
        .tx_send(tx_send),
        .tx_done(tx_done),
        .busy(busy),
        .grant_id(grant_id)
`ifdef UART_TX_SCHED_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- serializer model: start, 8 data LSB first, stop ----------------
    logic       m_active, m_line, m_done;
    int         m_tick, m_bit;
    logic [7:0] m_shreg;
    logic       line_log [10];
    logic       done_en, force_done;

    assign tx_done = (m_done & done_en) | force_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_line   <= 1'b1;
            m_done   <= 1'b0;
            m_tick   <= 0;
            m_bit    <= 0;
            m_shreg  <= 8'h00;
        end else begin
            m_done <= 1'b0;
            if (!m_active) begin
                if (tx_send) begin
                    m_active <= 1'b1;
                    m_line   <= 1'b0;
                    m_tick   <= 0;
                    m_bit    <= 0;
                end
            end else begin
                if (m_tick == TPB / 2) begin
                    line_log[m_bit] <= m_line;
                    if (m_bit == 0) m_shreg <= tx_data;
                end
                if (m_tick == TPB - 1) begin
                    m_tick <= 0;
                    if (m_bit == 9) begin
                        m_active <= 1'b0;
                        m_done   <= 1'b1;
                        m_line   <= 1'b1;
                    end else begin
                        m_bit  <= m_bit + 1;
                        m_line <= (m_bit == 8) ? 1'b1 : m_shreg[m_bit];
                    end
                end else begin
                    m_tick <= m_tick + 1;
                end
            end
        end
    end

    // ---------------- checking infrastructure ----------------
    int n_checks = 0;
    int n_errors = 0;
    int last_g   = NR - 1;
    int done_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arbiter: first valid index after the previous grant, modulo NR.
    function automatic int pick(input logic [NR-1:0] v);
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (last_g + k) % NR;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        last_g = NR - 1;
        #1;
    endtask

    // Called in an IDLE cycle with inputs applied; returns in the SEND cycle.
    task automatic accept_and_send(input int exp_w, input logic [7:0] exp_b, input bit chk_gap);
        logic [NR-1:0] exp_r;
        exp_r = NR'(1) << exp_w;
        chk("req_ready", 32'(req_ready), 32'(exp_r));
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("tx_send_pulse", 32'(tx_send), 1);
        chk("tx_data", 32'(tx_data), 32'(exp_b));
        chk("grant_id", 32'(grant_id), exp_w);
        chk("busy_send", 32'(busy), 1);
        chk("ready_in_send", 32'(req_ready), 0);
        if (chk_gap) chk("send_gap", cyc - done_cyc, 2);
        last_g = exp_w;
        $display("frame: grant=%0d data=0x%02h send_cycle=%0d", grant_id, tx_data, cyc);
    endtask

    // From the SEND cycle to the IDLE cycle after tx_done.
    task automatic finish_frame(input logic [7:0] exp_b);
        int n;
        @(negedge clk);
        #1;
        chk("tx_send_low", 32'(tx_send), 0);
        chk("busy_wait", 32'(busy), 1);
        n = 0;
        while (!tx_done && n < BUDGET) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("frame_done", 32'(tx_done), 1);
        done_cyc = cyc;
        chk("tx_data_hold", 32'(tx_data), 32'(exp_b));
        chk("ready_in_wait", 32'(req_ready), 0);
        @(negedge clk);
        #1;
        chk("busy_fall", 32'(busy), 0);
    endtask

    typedef struct {
        logic [NR-1:0]   valid;
        logic [8*NR-1:0] data;
        int              exp_w;
        logic [7:0]      exp_b;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [9:0]  got_line;
        logic [7:0]  bytes [NR];
        logic [7:0]  data_hold [NR];
        logic [NR-1:0] mask;
        int w, served, iter;

        // Expected grants hand-derived from the round-robin rule, starting after reset.
        tbl[0]  = '{4'b0110, 32'h00221100, 1, 8'h11};
        tbl[1]  = '{4'b0100, 32'h00220000, 2, 8'h22};
        tbl[2]  = '{4'b1000, 32'h01000000, 3, 8'h01};
        tbl[3]  = '{4'b1000, 32'h02000000, 3, 8'h02};
        tbl[4]  = '{4'b1000, 32'h03000000, 3, 8'h03};
        tbl[5]  = '{4'b1111, 32'h40302010, 0, 8'h10};
        tbl[6]  = '{4'b1111, 32'h40302010, 1, 8'h20};
        tbl[7]  = '{4'b1111, 32'h40302010, 2, 8'h30};
        tbl[8]  = '{4'b1111, 32'h40302010, 3, 8'h40};
        tbl[9]  = '{4'b1111, 32'h40302010, 0, 8'h10};
        tbl[10] = '{4'b1010, 32'h43002100, 1, 8'h21};
        tbl[11] = '{4'b1001, 32'h44000055, 3, 8'h44};
        tbl[12] = '{4'b1101, 32'h66770088, 0, 8'h88};

        done_en    = 1'b1;
        force_done = 1'b0;
        req_data   = '0;

        // Reset state, with valids asserted to show req_ready stays low in reset.
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tx_send", 32'(tx_send), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_grant_id", 32'(grant_id), NR - 1);
        chk("rst_req_ready", 32'(req_ready), 0);
`ifdef UART_TX_SCHED_TIMEOUT_EN
        chk("rst_timeout_err", 32'(timeout_err), 0);
`endif
        req_valid = '0;
        rst_n     = 1'b1;
        last_g    = NR - 1;
        @(negedge clk);
        #1;

        // Single requester 0 sends 0xA5; check the line bits the serializer produced.
        req_valid = 4'b0001;
        req_data  = 32'h000000A5;
        #1;
        accept_and_send(0, 8'hA5, 0);
        finish_frame(8'hA5);
        req_valid = '0;
        for (int k = 0; k < 10; k++) got_line[k] = line_log[k];
        chk("line_bits_A5", 32'(got_line), 32'h34A);

        // tx_done in IDLE is ignored.
        force_done = 1'b1;
        @(negedge clk);
        #1;
        force_done = 1'b0;
        chk("idle_done_busy", 32'(busy), 0);
        chk("idle_done_grant", 32'(grant_id), 0);

        // tx_done in SEND is ignored: WAIT still lasts until the real frame end.
        req_valid = 4'b0010;
        req_data  = 32'h00005A00;
        #1;
        accept_and_send(1, 8'h5A, 0);
        force_done = 1'b1;
        req_valid  = '0;
        @(negedge clk);
        #1;
        force_done = 1'b0;
        chk("send_done_ignored", 32'(busy), 1);
        finish_frame(8'h5A);

        // Table-driven sequence from reset.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            req_valid = tbl[i].valid;
            req_data  = tbl[i].data;
            #1;
            accept_and_send(tbl[i].exp_w, tbl[i].exp_b, i > 0);
            finish_frame(tbl[i].exp_b);
        end
        req_valid = '0;

        // All continuously valid: grants 0,1,2,3,0,1,2,3 with a 2-cycle done-to-send gap.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            bytes[i] = 8'(8'hA0 + i);
            req_data[8*i +: 8] = bytes[i];
        end
        req_valid = 4'b1111;
        #1;
        for (int f = 0; f < 8; f++) begin
            w = f % NR;
            accept_and_send(w, bytes[w], f > 0);
            finish_frame(bytes[w]);
            bytes[w] = 8'(bytes[w] + 8'h10);
            req_data[8*w +: 8] = bytes[w];
        end
        req_valid = '0;

        // Reset in SEND, then reset mid-WAIT: outputs clear without a clock edge.
        do_reset();
        req_valid = 4'b1111;
        req_data  = 32'h44332211;
        #1;
        accept_and_send(0, 8'h11, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_send_tx_send", 32'(tx_send), 0);
        chk("rst_send_busy", 32'(busy), 0);
        chk("rst_send_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        last_g = NR - 1;
        #1;
        accept_and_send(0, 8'h11, 0);
        repeat (6) @(negedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_wait_busy", 32'(busy), 0);
        chk("rst_wait_tx_send", 32'(tx_send), 0);
        chk("rst_wait_tx_data", 32'(tx_data), 0);
        chk("rst_wait_grant", 32'(grant_id), NR - 1);
        @(negedge clk);
        rst_n  = 1'b1;
        last_g = NR - 1;
        #1;
        accept_and_send(0, 8'h11, 0);
        finish_frame(8'h11);
        accept_and_send(1, 8'h22, 1);
        finish_frame(8'h22);
        req_valid = '0;

        // Randomized valid patterns against the reference arbiter.
        for (int i = 0; i < NR; i++) data_hold[i] = 8'($urandom);
        served = 0;
        iter   = 0;
        while (served < 12 && iter < 200) begin
            iter++;
            mask = NR'($urandom_range(0, 15));
            req_valid = mask;
            for (int i = 0; i < NR; i++) req_data[8*i +: 8] = data_hold[i];
            #1;
            if (mask == '0) begin
                chk("idle_no_ready", 32'(req_ready), 0);
                @(negedge clk);
                #1;
                chk("idle_no_busy", 32'(busy), 0);
            end else begin
                w = pick(mask);
                accept_and_send(w, data_hold[w], 0);
                finish_frame(data_hold[w]);
                data_hold[w] = 8'($urandom);
                served++;
            end
        end
        req_valid = '0;

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Watchdog: no tx_done, back to IDLE after TMO WAIT cycles, flag sticks.
        begin
            int k;
            req_valid = 4'b0001;
            req_data  = 32'h00000077;
            done_en   = 1'b0;
            #1;
            w = pick(4'b0001);
            accept_and_send(w, 8'h77, 0);
            k = 0;
            @(negedge clk);
            #1;
            while (busy && k < 300) begin
                k++;
                @(negedge clk);
                #1;
            end
            chk("timeout_len", k, TMO);
            chk("timeout_err_set", 32'(timeout_err), 1);
            done_en = 1'b1;
            w = pick(4'b0001);
            accept_and_send(w, 8'h77, 0);
            finish_frame(8'h77);
            chk("timeout_err_sticky", 32'(timeout_err), 1);
            req_valid = '0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
